inst_mem_responder: RTL and testbench

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

---
 rtl/inst_mem_responder_if.sv | 34 +++
 rtl/inst_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_inst_mem_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response channel between the IF stage (master) and the
// instruction memory responder (slave).
interface inst_mem_responder_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic [31:0] resp_pc;
    logic        resp_err;
    logic        resp_ready;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_instr,
        input  resp_pc,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_instr,
        output resp_pc,
        output resp_err
    );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: a 64-word program store that answers IF-stage
// fetches after a fixed number of wait cycles. The store is loaded through a
// separate write strobe that is honoured only while the responder is idle.
// A flush (taken branch) cancels any fetch in flight.
module inst_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    inst_mem_responder_if.slave        bus,
    input  logic                       flush,
    input  logic                       load_en,
    input  logic [5:0]                 load_addr,
    input  logic [31:0]                load_data,
    output logic                       busy
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_WAIT   = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;
    localparam logic [3:0]  WAIT_INIT = WAIT_CYCLES[3:0];
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    // Misaligned or beyond the 256-byte program window.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'd0) || (addr[31:8] != 24'd0);
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic        req_ready_s;
    logic        accept_s;
    logic        enter_resp_s;
    logic [31:0] rd_addr_s;
    logic [5:0]  rd_idx_s;
    logic        rd_err_s;
    logic [31:0] rd_data_s;
    logic        resp_valid_r;
    logic [31:0] resp_instr_r;
    logic [31:0] resp_pc_r;
    logic        resp_err_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    // Requests are only taken while idle, and never while a flush is pending.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready_s = !flush;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.req_valid && req_ready_s;

    // Next-state, wait counter and address capture. The counter reaches zero
    // one edge before RESP is entered, so the response is registered
    // WAIT_CYCLES+1 edges after acceptance.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        addr_s       = addr_r;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_s = bus.req_addr;
                    cnt_s  = WAIT_INIT;
                    if (WAIT_INIT != 4'd0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                // Flush wins over a simultaneous consumer handshake.
                if (flush || bus.resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Read address: the live request when entering RESP straight from IDLE,
    // otherwise the latched one.
    always_comb begin
        if (state_r == ST_IDLE) begin
            rd_addr_s = bus.req_addr;
        end else begin
            rd_addr_s = addr_r;
        end
    end

    // Word lookup; erroneous addresses never touch the array, and a load to
    // the same word on an idle edge is forwarded so the read sees it.
    always_comb begin
        rd_idx_s = rd_addr_s[7:2];
        rd_err_s = addr_err(rd_addr_s);
        if (rd_err_s) begin
            rd_data_s = NOP_INSTR;
        end else if (load_en && (state_r == ST_IDLE) && (load_addr == rd_idx_s)) begin
            rd_data_s = load_data;
        end else begin
            rd_data_s = mem_r[rd_idx_s];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
        end
    end

    // Response registers: payload captured on RESP entry and held otherwise;
    // valid tracks residence in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_instr_r <= 32'd0;
            resp_pc_r    <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= (state_s == ST_RESP);
            if (enter_resp_s) begin
                resp_instr_r <= rd_data_s;
                resp_pc_r    <= rd_addr_s;
                resp_err_r   <= rd_err_s;
            end
        end
    end

    // Program store; no reset so a reset never disturbs loaded code.
    always_ff @(posedge clk) begin
        if (load_en && (state_r == ST_IDLE)) begin
            mem_r[load_addr] <= load_data;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_instr = resp_instr_r;
    assign bus.resp_pc    = resp_pc_r;
    assign bus.resp_err   = resp_err_r;
    assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed testbench for inst_mem_responder (WAIT_CYCLES = 2).
module tb_inst_mem_responder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        busy;
    int          checks;
    int          failures;

    inst_mem_responder_if bus_if ();

    inst_mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request, then wait until the response should be registered.
    task automatic fetch_wait(input logic [31:0] addr);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        tick();
        bus_if.req_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic complete();
        bus_if.resp_ready = 1'b1;
        tick();
        bus_if.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_if.resp_valid); end
        checks++; if (bus_if.resp_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus_if.resp_instr); end
        checks++; if (bus_if.resp_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus_if.resp_pc); end
        checks++; if (bus_if.resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_if.resp_err); end
        checks++; if (bus_if.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus_if.req_ready); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_basic_fetch();
        load_en = 1'b1; load_addr = 6'd1; load_data = 32'hE3A01005;
        tick();
        load_en = 1'b0;
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h4;
        checks++; if (bus_if.req_ready !== 1'b1) begin failures++; $display("FAIL basic_req_ready got=%b exp=1", bus_if.req_ready); end
        tick();
        bus_if.req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        checks++; if (bus_if.req_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_wait got=%b exp=0", bus_if.req_ready); end
        for (int i = 1; i <= 2; i++) begin
            checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid edge=%0d got=%b exp=0", i - 1, bus_if.resp_valid); end
            tick();
        end
        checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid edge=2 got=%b exp=0", bus_if.resp_valid); end
        tick();
        checks++; if (bus_if.resp_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus_if.resp_valid); end
        checks++; if (bus_if.resp_instr !== 32'hE3A01005) begin failures++; $display("FAIL basic_instr got=%h exp=e3a01005", bus_if.resp_instr); end
        checks++; if (bus_if.resp_pc !== 32'h4) begin failures++; $display("FAIL basic_pc got=%h exp=4", bus_if.resp_pc); end
        checks++; if (bus_if.resp_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus_if.resp_err); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus_if.resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus_if.resp_valid); end
            checks++; if (bus_if.resp_instr !== 32'hE3A01005) begin failures++; $display("FAIL bp_instr cyc=%0d got=%h exp=e3a01005", i, bus_if.resp_instr); end
            checks++; if (bus_if.resp_pc !== 32'h4) begin failures++; $display("FAIL bp_pc cyc=%0d got=%h exp=4", i, bus_if.resp_pc); end
            checks++; if (bus_if.req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, bus_if.req_ready); end
        end
        complete();
        checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_done_valid got=%b exp=0", bus_if.resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_done_busy got=%b exp=0", busy); end
        checks++; if (bus_if.req_ready !== 1'b1) begin failures++; $display("FAIL bp_done_req_ready got=%b exp=1", bus_if.req_ready); end
        checks++; if (bus_if.resp_instr !== 32'hE3A01005) begin failures++; $display("FAIL bp_hold_instr got=%h exp=e3a01005", bus_if.resp_instr); end
    endtask

    task automatic test_flush();
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h4;
        tick();
        bus_if.req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus_if.resp_valid); end
        checks++; if (bus_if.req_ready !== 1'b0) begin failures++; $display("FAIL flush_req_ready got=%b exp=0", bus_if.req_ready); end
        flush = 1'b0;
        #1;
        checks++; if (bus_if.req_ready !== 1'b1) begin failures++; $display("FAIL flush_release_ready got=%b exp=1", bus_if.req_ready); end
        // New request with a same-edge load of the word it reads.
        load_en = 1'b1; load_addr = 6'd2; load_data = 32'hE2811001;
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h8;
        tick();
        load_en = 1'b0;
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_valid cyc=%0d got=%b exp=0", i, bus_if.resp_valid); end
        end
        tick();
        checks++; if (bus_if.resp_valid !== 1'b1) begin failures++; $display("FAIL flush_new_valid got=%b exp=1", bus_if.resp_valid); end
        checks++; if (bus_if.resp_pc !== 32'h8) begin failures++; $display("FAIL flush_new_pc got=%h exp=8", bus_if.resp_pc); end
        checks++; if (bus_if.resp_instr !== 32'hE2811001) begin failures++; $display("FAIL flush_new_instr got=%h exp=e2811001", bus_if.resp_instr); end
        complete();
    endtask

    task automatic test_errors();
        fetch_wait(32'h6);
        checks++; if (bus_if.resp_valid !== 1'b1) begin failures++; $display("FAIL err6_valid got=%b exp=1", bus_if.resp_valid); end
        checks++; if (bus_if.resp_err !== 1'b1) begin failures++; $display("FAIL err6_err got=%b exp=1", bus_if.resp_err); end
        checks++; if (bus_if.resp_instr !== 32'hE1A00000) begin failures++; $display("FAIL err6_instr got=%h exp=e1a00000", bus_if.resp_instr); end
        checks++; if (bus_if.resp_pc !== 32'h6) begin failures++; $display("FAIL err6_pc got=%h exp=6", bus_if.resp_pc); end
        complete();
        fetch_wait(32'h100);
        checks++; if (bus_if.resp_err !== 1'b1) begin failures++; $display("FAIL err100_err got=%b exp=1", bus_if.resp_err); end
        checks++; if (bus_if.resp_instr !== 32'hE1A00000) begin failures++; $display("FAIL err100_instr got=%h exp=e1a00000", bus_if.resp_instr); end
        checks++; if (bus_if.resp_pc !== 32'h100) begin failures++; $display("FAIL err100_pc got=%h exp=100", bus_if.resp_pc); end
        complete();
        fetch_wait(32'h8);
        checks++; if (bus_if.resp_err !== 1'b0) begin failures++; $display("FAIL ok8_err got=%b exp=0", bus_if.resp_err); end
        checks++; if (bus_if.resp_instr !== 32'hE2811001) begin failures++; $display("FAIL ok8_instr got=%h exp=e2811001", bus_if.resp_instr); end
        complete();
    endtask

    task automatic test_load_in_resp();
        fetch_wait(32'h4);
        load_en = 1'b1; load_addr = 6'd1; load_data = 32'h00000000;
        tick();
        load_en = 1'b0;
        checks++; if (bus_if.resp_valid !== 1'b1) begin failures++; $display("FAIL ldresp_valid got=%b exp=1", bus_if.resp_valid); end
        complete();
        fetch_wait(32'h4);
        checks++; if (bus_if.resp_instr !== 32'hE3A01005) begin failures++; $display("FAIL ldresp_refetch got=%h exp=e3a01005", bus_if.resp_instr); end
        complete();
    endtask

    task automatic test_reset_mid_wait();
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h4;
        tick();
        bus_if.req_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL rstw_valid got=%b exp=0", bus_if.resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%b exp=0", busy); end
        tick();
        tick();
        rst = 1'b1;
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h4;
        checks++; if (bus_if.req_ready !== 1'b1) begin failures++; $display("FAIL rstw_req_ready got=%b exp=1", bus_if.req_ready); end
        tick();
        bus_if.req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstw_first_accept got=%b exp=1", busy); end
        tick();
        tick();
        checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL rstw_stale_valid got=%b exp=0", bus_if.resp_valid); end
        tick();
        checks++; if (bus_if.resp_valid !== 1'b1) begin failures++; $display("FAIL rstw_new_valid got=%b exp=1", bus_if.resp_valid); end
        checks++; if (bus_if.resp_instr !== 32'hE3A01005) begin failures++; $display("FAIL rstw_mem_kept got=%h exp=e3a01005", bus_if.resp_instr); end
        complete();
        fetch_wait(32'h8);
        checks++; if (bus_if.resp_instr !== 32'hE2811001) begin failures++; $display("FAIL rstw_mem2_kept got=%h exp=e2811001", bus_if.resp_instr); end
        complete();
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b0;
        flush             = 1'b0;
        load_en           = 1'b0;
        load_addr         = 6'd0;
        load_data         = 32'd0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_addr   = 32'd0;
        bus_if.resp_ready = 1'b0;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush();
        test_errors();
        test_load_in_resp();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
